// File: rtl/merge_arb_pkg.sv
// Shared constants and types for the merge_memory read-port arbiter.
// Requester IDs double as the round-robin pointer encoding and the response tag.
package merge_arb_pkg;

    localparam logic REQ_WFG        = 1'b0;
    localparam logic REQ_WB         = 1'b1;
    localparam int   MAX_RD_LATENCY = 3;
    localparam int   STAT_W         = 16;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_entry_t;

endpackage

// File: rtl/merge_arb_rr2.sv
// Two-way round-robin grant with its priority pointer register.
// The grant is combinational; the pointer moves to the non-granted requester.
module merge_arb_rr2
    import merge_arb_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr_reg;
    logic ptr_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= REQ_WFG;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // No grant while reset is held, so nothing can be accepted and then dropped silently.
    always_comb begin
        grant    = 2'b00;
        ptr_next = ptr_reg;
        if (!srst) begin
            if (req[0] && (!req[1] || ptr_reg == REQ_WFG)) begin
                grant    = 2'b01;
                ptr_next = REQ_WB;
            end else if (req[1]) begin
                grant    = 2'b10;
                ptr_next = REQ_WFG;
            end
        end
    end

endmodule

// File: rtl/merge_memory_arbiter.sv
// Shares the merged 1024x32 merge_memory read port between the waveform fetch and Wishbone readback.
// Optional grant counters are built when MERGE_ARB_STATS_EN is defined.
module merge_memory_arbiter
    import merge_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int AW         = 10,
    parameter int DW         = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_data,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_data,
    output logic          mem_csb,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout
`ifdef MERGE_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_grant0,
    output logic [STAT_W-1:0] stat_grant1
`endif
);

    logic [1:0]    req_vec;
    logic [1:0]    grant;
    logic          accept;
    logic          grant_id;
    logic [AW-1:0] grant_addr;

    assign req_vec = {req1_valid, req0_valid};

    merge_arb_rr2 u_rr2 (
        .clk   (wb_clk_i),
        .srst  (wb_rst_i),
        .req   (req_vec),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign grant_id   = grant[1] ? REQ_WB : REQ_WFG;
    assign grant_addr = grant[1] ? req1_addr : req0_addr;

    logic          mem_csb_reg;
    logic [AW-1:0] mem_addr_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mem_csb_reg  <= 1'b1;
            mem_addr_reg <= '0;
        end else begin
            mem_csb_reg <= !accept;
            if (accept) begin
                mem_addr_reg <= grant_addr;
            end
        end
    end

    assign mem_csb  = mem_csb_reg;
    assign mem_addr = mem_addr_reg;

    // Stage 0 is loaded on the accept edge; stage RD_LATENCY lines up with valid mem_dout.
    tag_entry_t tag_pipe_reg [0:RD_LATENCY];
    tag_entry_t tag_next     [0:RD_LATENCY];
    tag_entry_t tag_mature;

    assign tag_next[0] = tag_entry_t'{valid: accept, id: grant_id};

    genvar gi;
    generate
        for (gi = 1; gi <= RD_LATENCY; gi++) begin : g_tag
            assign tag_next[gi] = tag_pipe_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                tag_pipe_reg[i] <= '0;
            end
        end else begin
            tag_pipe_reg <= tag_next;
        end
    end

    assign tag_mature = tag_pipe_reg[RD_LATENCY];

    logic          rsp0_valid_reg;
    logic          rsp1_valid_reg;
    logic [DW-1:0] rsp0_data_reg;
    logic [DW-1:0] rsp1_data_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            rsp0_data_reg  <= '0;
            rsp1_data_reg  <= '0;
        end else begin
            rsp0_valid_reg <= tag_mature.valid && (tag_mature.id == REQ_WFG);
            rsp1_valid_reg <= tag_mature.valid && (tag_mature.id == REQ_WB);
            if (tag_mature.valid && tag_mature.id == REQ_WFG) begin
                rsp0_data_reg <= mem_dout;
            end
            if (tag_mature.valid && tag_mature.id == REQ_WB) begin
                rsp1_data_reg <= mem_dout;
            end
        end
    end

    assign rsp0_valid = rsp0_valid_reg;
    assign rsp1_valid = rsp1_valid_reg;
    assign rsp0_data  = rsp0_data_reg;
    assign rsp1_data  = rsp1_data_reg;

`ifdef MERGE_ARB_STATS_EN
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            logic [STAT_W-1:0] cnt_reg;
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i || stat_clr) begin
                    cnt_reg <= '0;
                end else if (grant[gi] && cnt_reg != {STAT_W{1'b1}}) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign stat_grant0 = g_stat[0].cnt_reg;
    assign stat_grant1 = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_merge_memory_arbiter.sv
// Scoreboard bench for merge_memory_arbiter with a 1-cycle-latency merge_memory model.
// Stats checks are compiled in when MERGE_ARB_STATS_EN is defined.
module tb_merge_memory_arbiter;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [9:0]  req0_addr  = '0;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [31:0] rsp0_data;
    logic        req1_valid = 1'b0;
    logic [9:0]  req1_addr  = '0;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [31:0] rsp1_data;
    logic        mem_csb;
    logic [9:0]  mem_addr;
    logic [31:0] mem_dout = '0;
`ifdef MERGE_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_grant0;
    logic [15:0] stat_grant1;
`endif

    merge_memory_arbiter #(.RD_LATENCY(RD_LAT), .AW(10), .DW(32)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .mem_csb    (mem_csb),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout)
`ifdef MERGE_ARB_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_grant0 (stat_grant0),
        .stat_grant1 (stat_grant1)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem_array [0:1023];

    always @(posedge clk) begin
        if (!mem_csb) mem_dout <= mem_array[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          cyc;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    logic        mon_en   = 1'b0;
    int          cyc      = 0;
    int          rsp_cnt  = 0;
    logic        exp_csb  = 1'b1;
    logic [9:0]  exp_addr = '0;
    logic        exp_ptr  = 1'b0;
    logic [31:0] last_d0  = '0;
    logic [31:0] last_d1  = '0;

    // Observes each cycle away from the edge: responses, issue registers, grants.
    always @(negedge clk) begin
        if (mon_en) begin
            logic eg0, eg1;
            sb_entry_t e;
            cyc++;
            if (rsp0_valid && rsp1_valid) check_val("rsp_both", 32'd1, 32'd0);
            if (rsp0_valid || rsp1_valid) begin
                rsp_cnt++;
                if (sb_q.size() == 0) begin
                    check_val("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("rsp_id", {31'd0, rsp1_valid}, {31'd0, e.id});
                    check_val("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e.data);
                    check_val("rsp_lat", cyc - e.cyc, RD_LAT + 2);
                    $display("rsp id=%0d data=%08h cyc=%0d", rsp1_valid, rsp1_valid ? rsp1_data : rsp0_data, cyc);
                end
            end
            if (!rsp0_valid) check_val("rsp0_hold", rsp0_data, last_d0);
            if (!rsp1_valid) check_val("rsp1_hold", rsp1_data, last_d1);
            if (rsp0_valid) last_d0 = rsp0_data;
            if (rsp1_valid) last_d1 = rsp1_data;
            check_val("mem_csb", {31'd0, mem_csb}, {31'd0, exp_csb});
            check_val("mem_addr", {22'd0, mem_addr}, {22'd0, exp_addr});
            eg0 = !rst && req0_valid && (!req1_valid || exp_ptr == 1'b0);
            eg1 = !rst && req1_valid && !eg0;
            check_val("req0_ready", {31'd0, req0_ready}, {31'd0, eg0});
            check_val("req1_ready", {31'd0, req1_ready}, {31'd0, eg1});
            if (rst) begin
                sb_q.delete();
                exp_csb  = 1'b1;
                exp_addr = '0;
                exp_ptr  = 1'b0;
                last_d0  = '0;
                last_d1  = '0;
            end else begin
                exp_csb = !(eg0 || eg1);
                if (eg0) begin
                    sb_q.push_back('{id: 1'b0, data: mem_array[req0_addr], cyc: cyc});
                    exp_addr = req0_addr;
                    exp_ptr  = 1'b1;
                    $display("accept req0 addr=%03h cyc=%0d", req0_addr, cyc);
                end else if (eg1) begin
                    sb_q.push_back('{id: 1'b1, data: mem_array[req1_addr], cyc: cyc});
                    exp_addr = req1_addr;
                    exp_ptr  = 1'b0;
                    $display("accept req1 addr=%03h cyc=%0d", req1_addr, cyc);
                end
            end
        end
    end

    task automatic drive(input logic v0, input logic [9:0] a0, input logic v1, input logic [9:0] a1,
                         output logic r0, output logic r1);
        req0_valid = v0;
        req0_addr  = a0;
        req1_valid = v1;
        req1_addr  = a1;
        #2;
        r0 = req0_ready;
        r1 = req1_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic r0, r1;
        logic [9:0] baddr [3];
        int snap;
        for (int i = 0; i < 1024; i++) begin
            mem_array[i] = {i[9:0], ~i[9:0], 12'hA5C};
        end
        mem_array[5] = 32'hDEADBEEF;
        baddr[0] = 10'h1FF;
        baddr[1] = 10'h200;
        baddr[2] = 10'h3FF;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_csb", {31'd0, mem_csb}, 32'd1);
        check_val("rst_addr", {22'd0, mem_addr}, 32'd0);
        check_val("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check_val("rst_rsp0_data", rsp0_data, 32'd0);
        check_val("rst_rsp1_data", rsp1_data, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(1);

        // Single read of 0x005.
        drive(1'b1, 10'h005, 1'b0, 10'h000, r0, r1);
        check_val("single_ready", {31'd0, r0}, 32'd1);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        check_val("single_early", {31'd0, rsp0_valid}, 32'd0);
        @(posedge clk); #1;
        check_val("single_valid", {31'd0, rsp0_valid}, 32'd1);
        check_val("single_data", rsp0_data, 32'hDEADBEEF);
        check_val("single_rsp1", {31'd0, rsp1_valid}, 32'd0);
        @(posedge clk); #1;
        check_val("single_pulse", {31'd0, rsp0_valid}, 32'd0);
        check_val("single_hold", rsp0_data, 32'hDEADBEEF);
        idle(2);

        // Back-to-back req1 then req0.
        drive(1'b0, 10'h000, 1'b1, 10'h123, r0, r1);
        drive(1'b1, 10'h045, 1'b0, 10'h000, r0, r1);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        check_val("tag_rsp1", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
        check_val("tag_data1", rsp1_data, mem_array[10'h123]);
        @(posedge clk); #1;
        check_val("tag_rsp0", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
        check_val("tag_data0", rsp0_data, mem_array[10'h045]);
        idle(2);

        // Boundary addresses, plus 0x000 through requester 1.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, baddr[i], 1'b0, 10'h000, r0, r1);
            check_val("bnd_addr", {22'd0, mem_addr}, {22'd0, baddr[i]});
        end
        drive(1'b0, 10'h000, 1'b1, 10'h000, r0, r1);
        check_val("bnd_addr0", {22'd0, mem_addr}, 32'd0);
        idle(4);

        // Reset the cycle after an accept; the pointer was left at requester 1.
        drive(1'b1, 10'h077, 1'b0, 10'h000, r0, r1);
        req0_valid = 1'b0;
        rst  = 1'b1;
        snap = rsp_cnt;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("midrst_csb", {31'd0, mem_csb}, 32'd1);
        rst = 1'b0;
        idle(4);
        check_val("midrst_no_rsp", rsp_cnt, snap);

        // Contention: both valid for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10'h010, 1'b1, 10'h210, r0, r1);
            check_val("cont_grant", {30'd0, r1, r0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            check_val("cont_addr", {22'd0, mem_addr}, (i % 2 == 0) ? 32'h010 : 32'h210);
        end
        idle(4);

`ifdef MERGE_ARB_STATS_EN
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 10'(i), 1'b0, 10'h000, r0, r1);
        for (int i = 0; i < 3; i++) drive(1'b0, 10'h000, 1'b1, 10'(i + 8), r0, r1);
        idle(4);
        check_val("stat_grant0", {16'd0, stat_grant0}, 32'd5);
        check_val("stat_grant1", {16'd0, stat_grant1}, 32'd3);
        stat_clr = 1'b1;
        drive(1'b1, 10'h030, 1'b0, 10'h000, r0, r1);
        stat_clr = 1'b0;
        idle(1);
        check_val("stat_clr0", {16'd0, stat_grant0}, 32'd0);
        check_val("stat_clr1", {16'd0, stat_grant1}, 32'd0);
        idle(3);
`endif

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), r0, r1);
        end
        idle(6);
        check_val("sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
